// File: rtl/gcd_pkg.sv
// Shared types for the GCD operand sequencer: FSM state encoding and the buffered operand pair.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    WAIT,
    RESP
  } gcd_seq_state_e;

  typedef struct packed {
    logic [GCD_WIDTH-1:0] a;
    logic [GCD_WIDTH-1:0] b;
  } gcd_pair_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous operand-pair FIFO; pointers carry an extra wrap bit so full and empty are distinguishable.
module gcd_pair_fifo
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  gcd_pair_t              push_data,
  input  logic                   pop,
  output gcd_pair_t              pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  gcd_pair_t       mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is data-only and needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Feeds operand pairs to the serial-load GCD engine (Start/In protocol) and returns results with a watchdog.
// Optional build macro GCD_SEQ_ZERO_BYPASS_EN: pairs with a zero operand are answered without the engine.
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_a,
  input  logic [WIDTH-1:0]       req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_a,
  output logic [WIDTH-1:0]       rsp_b,
  output logic [WIDTH-1:0]       rsp_gcd,
  output logic                   rsp_err,
  output logic                   gcd_start,
  output logic [WIDTH-1:0]       gcd_in,
  input  logic [WIDTH-1:0]       gcd_out,
  input  logic                   gcd_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  gcd_seq_state_e   state_q, state_n;
  gcd_pair_t        push_pair, head;
  logic             fifo_full, fifo_empty, pop, bypass;
  logic [CW-1:0]    wd_q, wd_n;
  logic [WIDTH-1:0] a_n, b_n, gcd_n, in_n;
  logic             err_n, start_n;

  assign push_pair.a = req_a;
  assign push_pair.b = req_b;
  assign req_ready   = !fifo_full;

  gcd_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid && req_ready),
    .push_data (push_pair),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_comb begin
`ifdef GCD_SEQ_ZERO_BYPASS_EN
    bypass = (head.a == '0) || (head.b == '0);
`else
    bypass = 1'b0;
`endif
  end

  // rsp_a/rsp_b double as the working A/B registers; they only matter to the consumer in RESP.
  always_comb begin
    state_n = state_q;
    a_n     = rsp_a;
    b_n     = rsp_b;
    gcd_n   = rsp_gcd;
    err_n   = rsp_err;
    in_n    = gcd_in;
    start_n = 1'b0;
    wd_n    = wd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          a_n = head.a;
          b_n = head.b;
          if (bypass) begin
            pop     = 1'b1;
            gcd_n   = head.a | head.b;
            err_n   = 1'b0;
            state_n = RESP;
          end else begin
            start_n = 1'b1;
            in_n    = head.a;
            state_n = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        in_n    = rsp_b;
        state_n = LOAD_B;
      end
      LOAD_B: begin
        pop     = 1'b1;
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // Done outranks the watchdog when both land on the same edge.
        if (gcd_done) begin
          gcd_n   = gcd_out;
          err_n   = 1'b0;
          state_n = RESP;
        end else if (wd_q == WD_LAST) begin
          gcd_n   = '0;
          err_n   = 1'b1;
          state_n = RESP;
        end else begin
          wd_n = wd_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      rsp_a     <= '0;
      rsp_b     <= '0;
      rsp_gcd   <= '0;
      rsp_err   <= 1'b0;
      rsp_valid <= 1'b0;
      gcd_start <= 1'b0;
      gcd_in    <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      wd_q      <= wd_n;
      rsp_a     <= a_n;
      rsp_b     <= b_n;
      rsp_gcd   <= gcd_n;
      rsp_err   <= err_n;
      rsp_valid <= (state_n == RESP);
      gcd_start <= start_n;
      gcd_in    <= in_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for gcd_operand_sequencer with a behavioural serial-load GCD engine (TIMEOUT=16).
module tb_gcd_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_a, rsp_b, rsp_gcd;
  logic        rsp_err;
  logic        gcd_start;
  logic [15:0] gcd_in, gcd_out;
  logic        gcd_done;
  logic        busy;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  gcd_operand_sequencer #(.WIDTH(16), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
    .gcd_start(gcd_start), .gcd_in(gcd_in), .gcd_out(gcd_out), .gcd_done(gcd_done),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  // Behavioural engine: Start+In(A), then In(B), Done with Out after eng_lat cycles.
  int          eng_lat = 1;
  logic        eng_hang = 1'b0;
  logic        eng_stale = 1'b0;
  int          ph = 0;
  int          ecnt = 0;
  int          ph0;
  logic [15:0] ea, eb;

  function automatic logic [15:0] euclid(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p = x, q = y, t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      ph = 0; gcd_done = 1'b0; gcd_out = '0;
    end else begin
      ph0 = ph;
      gcd_done = 1'b0;
      gcd_out  = '0;
      if (gcd_start) begin
        ea = gcd_in; ph = 1;
      end else if (ph == 1) begin
        eb = gcd_in; ecnt = eng_lat; ph = 2;
      end else if (ph == 2 && !eng_hang) begin
        ecnt--;
        if (ecnt == 0) begin
          gcd_done = 1'b1; gcd_out = euclid(ea, eb); ph = 0;
        end
      end
      if (eng_stale && ph0 != 2 && !gcd_done) begin
        gcd_done = 1'b1; gcd_out = 16'd99;
      end
    end
  end

  int starts = 0;
  int start_in_resp = 0;
  int rv_cnt = 0;
  always @(negedge clk) begin
    if (gcd_start === 1'b1) starts++;
    if (gcd_start === 1'b1 && rsp_valid === 1'b1) start_in_resp++;
    if (rsp_valid === 1'b1) rv_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    req_valid = 1'b1; req_a = a; req_b = b;
    while (req_ready !== 1'b1 && n < 300) begin step(); n++; end
    if (n >= 300) chk("push_ready_timeout", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                         input logic [15:0] xg, input logic xe);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin step(); n++; end
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_a"},     32'(rsp_a),     32'(xa));
    chk({nm, "_b"},     32'(rsp_b),     32'(xb));
    chk({nm, "_gcd"},   32'(rsp_gcd),   32'(xg));
    chk({nm, "_err"},   32'(rsp_err),   32'(xe));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] g;
  } vec_t;

  vec_t        tv[6];
  logic [15:0] qa[7], qb[7], qg[7];

  initial begin
    int s0, r0, idx;
    tv[0] = '{16'd35,    16'd14,  2,  16'd7};
    tv[1] = '{16'd17,    16'd5,   1,  16'd1};
    tv[2] = '{16'd100,   16'd75,  3,  16'd25};
    tv[3] = '{16'd65535, 16'd255, 4,  16'd255};
    tv[4] = '{16'd48,    16'd48,  1,  16'd48};
    tv[5] = '{16'd40,    16'd24,  16, 16'd8};   // Done coincides with the last watchdog cycle
    qa = '{16'd3, 16'd8, 16'd9, 16'd10, 16'd49, 16'd11, 16'd13};
    qb = '{16'd9, 16'd12, 16'd6, 16'd4, 16'd14, 16'd22, 16'd26};
    qg = '{16'd3, 16'd4, 16'd3, 16'd2, 16'd7, 16'd11, 16'd13};

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_gcd_start", 32'(gcd_start), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_gcd_in",    32'(gcd_in),    32'd0);
    chk("rst_rsp_a",     32'(rsp_a),     32'd0);
    chk("rst_rsp_gcd",   32'(rsp_gcd),   32'd0);
    rst = 1'b0;
    step();

    // Exact timing of a single pair, engine latency 5.
    eng_lat = 5;
    s0 = starts;
    req_valid = 1'b1; req_a = 16'd12; req_b = 16'd18;
    step();                                   // edge k: accepted
    req_valid = 1'b0;
    chk("t_k_level", 32'(level), 32'd1);
    chk("t_k_busy",  32'(busy),  32'd0);
    step();                                   // k+1: LOAD_A
    chk("t_k1_start", 32'(gcd_start), 32'd1);
    chk("t_k1_in",    32'(gcd_in),    32'd12);
    chk("t_k1_busy",  32'(busy),      32'd1);
    step();                                   // k+2: LOAD_B
    chk("t_k2_start", 32'(gcd_start), 32'd0);
    chk("t_k2_in",    32'(gcd_in),    32'd18);
    chk("t_k2_level", 32'(level),     32'd1);
    step();                                   // k+3: WAIT
    chk("t_k3_level", 32'(level),     32'd0);
    chk("t_k3_in",    32'(gcd_in),    32'd18);
    repeat (4) step();                        // k+7
    chk("t_k7_valid", 32'(rsp_valid), 32'd0);
    step();                                   // k+8
    chk("t_k8_valid", 32'(rsp_valid), 32'd1);
    get_rsp("t_single", 16'd12, 16'd18, 16'd6, 1'b0);
    chk("t_single_starts", 32'(starts - s0), 32'd1);

    for (int i = 0; i < 6; i++) begin
      eng_lat = tv[i].lat;
      s0 = starts;
      push(tv[i].a, tv[i].b);
      get_rsp($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].g, 1'b0);
      chk($sformatf("vec%0d_starts", i), 32'(starts - s0), 32'd1);
    end

    // Burst while the consumer stalls: FIFO fills to DEPTH behind a held response.
    eng_lat = 2;
    push(qa[0], qb[0]);
    for (int n = 0; n < 50 && rsp_valid !== 1'b1; n++) step();
    chk("burst_hold_valid", 32'(rsp_valid), 32'd1);
    idx = 1;
    for (int c = 0; c < 6; c++) begin
      if (req_ready === 1'b1 && idx < 7) begin
        req_valid = 1'b1; req_a = qa[idx]; req_b = qb[idx]; idx++;
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    req_valid = 1'b0;
    chk("burst_accepted", 32'(idx - 1), 32'd4);
    chk("burst_ready",    32'(req_ready), 32'd0);
    chk("burst_level",    32'(level),     32'd4);
    for (int i = 0; i < 5; i++) get_rsp($sformatf("drain%0d", i), qa[i], qb[i], qg[i], 1'b0);
    chk("start_in_resp", 32'(start_in_resp), 32'd0);

    // Watchdog: hung engine, response 16 cycles after WAIT entry.
    eng_hang = 1'b1;
    push(16'd7, 16'd21);                      // now just after edge k
    repeat (18) step();
    chk("wd_early_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("wd_valid", 32'(rsp_valid), 32'd1);
    chk("wd_err",   32'(rsp_err),   32'd1);
    chk("wd_gcd",   32'(rsp_gcd),   32'd0);
    chk("wd_a",     32'(rsp_a),     32'd7);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    eng_hang = 1'b0; eng_lat = 3;
    push(16'd21, 16'd14);
    get_rsp("wd_next", 16'd21, 16'd14, 16'd7, 1'b0);

    // Stale Done outside WAIT must be ignored.
    eng_stale = 1'b1; eng_lat = 3;
    push(16'd24, 16'd36);
    get_rsp("stale", 16'd24, 16'd36, 16'd12, 1'b0);
    eng_stale = 1'b0;
    step();

    // Zero operand pair.
    s0 = starts;
`ifdef GCD_SEQ_ZERO_BYPASS_EN
    push(16'd0, 16'd9);
    get_rsp("zero", 16'd0, 16'd9, 16'd9, 1'b0);
    push(16'd0, 16'd0);
    get_rsp("zero2", 16'd0, 16'd0, 16'd0, 1'b0);
    chk("zero_starts", 32'(starts - s0), 32'd0);
`else
    eng_hang = 1'b1;
    push(16'd0, 16'd9);
    get_rsp("zero", 16'd0, 16'd9, 16'd0, 1'b1);
    chk("zero_starts", 32'(starts - s0), 32'd1);
    eng_hang = 1'b0;
`endif

    // Reset during WAIT with three pairs queued.
    eng_hang = 1'b1;
    push(16'd30, 16'd12);
    push(16'd1, 16'd2);
    push(16'd3, 16'd4);
    push(16'd5, 16'd6);
    step();
    chk("mid_level", 32'(level), 32'd3);
    chk("mid_busy",  32'(busy),  32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_level", 32'(level),     32'd0);
    chk("mrst_busy",  32'(busy),      32'd0);
    chk("mrst_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_start", 32'(gcd_start), 32'd0);
    step();
    rst = 1'b0;
    eng_hang = 1'b0;
    s0 = starts; r0 = rv_cnt;
    repeat (30) step();
    chk("mrst_no_start", 32'(starts - s0), 32'd0);
    chk("mrst_no_rsp",   32'(rv_cnt - r0), 32'd0);
    chk("mrst_ready",    32'(req_ready),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/gcd_operand_sequencer.md
# gcd_operand_sequencer

Upstream feeder for the serial-load GCD engine. Accepts operand pairs on a valid/ready request port, buffers them in a small FIFO, and serializes each pair into the engine's two-cycle Start/In load protocol. Waits for the engine's Done, then returns the operands with the result on a valid/ready response port. A watchdog guarantees forward progress if the engine never completes.

## Interface
- WIDTH, 16: operand/result width; equals the GCD engine's In/Out width.
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- TIMEOUT, 1024: maximum WAIT cycles before the watchdog aborts; ≥4.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  operand pair offered
- req_ready  out  1  FIFO not full
- req_a, req_b  in  WIDTH  operands
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer accepts result
- rsp_a, rsp_b  out  WIDTH  operands of this result
- rsp_gcd  out  WIDTH  GCD result
- rsp_err  out  1  watchdog abort; rsp_gcd = 0
- gcd_start  out  1  to engine Start
- gcd_in  out  WIDTH  to engine In
- gcd_out  in  WIDTH  from engine Out
- gcd_done  in  1  from engine Done
- busy  out  1  state ≠ IDLE
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push on `req_valid && req_ready`. `req_ready = !full`, independent of a same-cycle pop. A full FIFO never accepts, even while popping.
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- IDLE: if the FIFO is non-empty, go to LOAD_A. Head pair is latched into working registers A/B on this transition.
- LOAD_A: `gcd_start=1`, `gcd_in=A`; go to LOAD_B.
- LOAD_B: `gcd_start=0`, `gcd_in=B`; pop the FIFO; clear the watchdog counter; go to WAIT.
- WAIT: `gcd_in=B` held.
  - `gcd_done=1`: capture `gcd_out` into rsp_gcd, set `rsp_err=0`, go to RESP.
  - Counter reaches TIMEOUT-1 without Done: set `rsp_gcd=0`, `rsp_err=1`, go to RESP.
  - Done and timeout in the same cycle: Done wins.
- gcd_done is ignored in IDLE, LOAD_A and LOAD_B, so stale Done from the previous operation is discarded.
- RESP: `rsp_valid=1`; rsp_a/rsp_b/rsp_gcd/rsp_err are stable until `rsp_ready`. On `rsp_ready`, go to IDLE.
- All outputs are registered (Moore).
- Reset values: `req_ready=1`; `rsp_valid=0`, `rsp_err=0`, `gcd_start=0`, `busy=0`, `level=0`; rsp_a/rsp_b/rsp_gcd and `gcd_in` = 0; FIFO empty; state IDLE.
- Reset asserted mid-operation: the in-flight pair and all queued pairs are discarded; `gcd_start` drops immediately.

## Timing
- Request accepted at edge k.
- LOAD_A is visible after edge k+1, LOAD_B after k+2, WAIT after k+3.
- Earliest Done sampled at edge k+4; `rsp_valid` high after edge k+4.
- Throughput: one pair per (4 + engine latency + response stall) cycles.
- `gcd_start` is a single-cycle pulse per pair.
- Back-to-back pairs: RESP→IDLE→LOAD_A, so at least one idle cycle separates consecutive Start pulses.
- `level` is updated on the same edge as push/pop.

## Configuration
- `GCD_SEQ_ZERO_BYPASS_EN` defined:
  - In IDLE, a head pair with A==0 or B==0 is popped without touching the engine.
  - Goes directly to RESP with `rsp_gcd` = the nonzero operand (0 if both are zero) and `rsp_err=0`.
  - No gcd_start pulse is issued for that pair.
- Not defined: zero pairs follow the normal LOAD path; a hung engine is then caught by the watchdog.

## Structure
- Shared package `gcd_pkg`: `gcd_seq_state_e` enum, default WIDTH constant, operand-pair struct type `gcd_pair_t` {a, b}.
- One sub-module, `gcd_pair_fifo`:
  - Synchronous DEPTH×gcd_pair_t FIFO with push/pop/full/empty/level.
  - Pointer wrap uses an extra MSB to distinguish full from empty.

## Test plan
- Single pair a=12, b=18 with a model engine that returns 6 after 5 cycles -> one gcd_start pulse with gcd_in=12, next cycle gcd_in=18; rsp_valid with rsp_gcd=6, rsp_err=0, rsp_a=12, rsp_b=18.
- Burst of 6 pairs with rsp_ready held 0 -> req_ready falls after 4 accepted (DEPTH=4); level=4; responses drain in order as rsp_ready is pulsed, with no Start pulse while in RESP.
- Engine never raises Done, TIMEOUT=16 -> rsp_valid 16 cycles after WAIT entry with rsp_err=1, rsp_gcd=0; next pair is processed normally.
- Stale gcd_done held high during LOAD_A/LOAD_B -> ignored; result captured only from Done in WAIT.
- rst asserted during WAIT with 3 pairs queued -> next cycle: level=0, busy=0, rsp_valid=0, gcd_start=0; no response is ever produced for those pairs.
- Pair a=0, b=9 -> with GCD_SEQ_ZERO_BYPASS_EN: rsp_gcd=9 with no gcd_start; without the macro: a Start pulse is issued, and the watchdog fires if the model engine hangs.
